// File: rtl/mips_main_ctrl.sv
// Multicycle MIPS main controller.
// A 4-bit state register walks each instruction through fetch, decode,
// execute, memory and write-back. All datapath enables and mux selects are
// decoded combinationally from the current state. Fetch and the data-memory
// states wait on the memory ready handshake.
module mips_main_ctrl #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       iorD,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regDst,
  output logic       memtoReg,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSrc,
  output logic       pcWrite,
  output logic       branch,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_e state_q, state_d;
  logic   rdy;

  // With the handshake disabled memory is assumed to finish in one cycle.
  assign rdy   = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state = state_q;

  // State register; reset forces FETCH at once so no write strobe survives it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Next-state and output decode from the current state.
  always_comb begin
    state_d    = S_FETCH;
    iorD       = 1'b0;
    memWrite   = 1'b0;
    irWrite    = 1'b0;
    regDst     = 1'b0;
    memtoReg   = 1'b0;
    regWrite   = 1'b0;
    aluSrcA    = 1'b0;
    aluSrcB    = 2'b00;
    aluOp      = 2'b00;
    pcSrc      = 2'b00;
    pcWrite    = 1'b0;
    branch     = 1'b0;
    illegal_op = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        // PC+4 computed every cycle, but PC and IR only load once memory is ready.
        aluSrcB = 2'b01;
        irWrite = rdy;
        pcWrite = rdy;
        state_d = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut.
        aluSrcB = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iorD    = 1'b1;
        state_d = rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoReg = 1'b1;
        regWrite = 1'b1;
      end
      S_MEMWR: begin
        // Strobe held for the whole access, including wait cycles.
        iorD     = 1'b1;
        memWrite = 1'b1;
        state_d  = rdy ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        aluSrcA = 1'b1;
        aluOp   = 2'b10;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regDst   = 1'b1;
        regWrite = 1'b1;
      end
      S_BEQEX: begin
        aluSrcA = 1'b1;
        aluOp   = 2'b01;
        pcSrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regWrite = 1'b1;
      end
      S_JEX: begin
        pcSrc   = 2'b10;
        pcWrite = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_main_ctrl.sv
// Directed table-driven bench for the multicycle MIPS main controller.
module tb_mips_main_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic       mem_ready;
  logic       iorD, memWrite, irWrite, regDst, memtoReg, regWrite, aluSrcA;
  logic [1:0] aluSrcB, aluOp, pcSrc;
  logic       pcWrite, branch, illegal_op;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  mips_main_ctrl #(.MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .iorD(iorD), .memWrite(memWrite), .irWrite(irWrite), .regDst(regDst),
    .memtoReg(memtoReg), .regWrite(regWrite), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSrc(pcSrc), .pcWrite(pcWrite),
    .branch(branch), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // Control word order:
  // iorD memWrite irWrite regDst memtoReg regWrite aluSrcA aluSrcB aluOp pcSrc pcWrite branch illegal_op
  localparam logic [15:0] C_FETCH1 = 16'b0_0_1_0_0_0_0_01_00_00_1_0_0;
  localparam logic [15:0] C_FETCH0 = 16'b0_0_0_0_0_0_0_01_00_00_0_0_0;
  localparam logic [15:0] C_DEC    = 16'b0_0_0_0_0_0_0_11_00_00_0_0_0;
  localparam logic [15:0] C_DECILL = 16'b0_0_0_0_0_0_0_11_00_00_0_0_1;
  localparam logic [15:0] C_MEMADR = 16'b0_0_0_0_0_0_1_10_00_00_0_0_0;
  localparam logic [15:0] C_MEMRD  = 16'b1_0_0_0_0_0_0_00_00_00_0_0_0;
  localparam logic [15:0] C_MEMWB  = 16'b0_0_0_0_1_1_0_00_00_00_0_0_0;
  localparam logic [15:0] C_MEMWR  = 16'b1_1_0_0_0_0_0_00_00_00_0_0_0;
  localparam logic [15:0] C_REX    = 16'b0_0_0_0_0_0_1_00_10_00_0_0_0;
  localparam logic [15:0] C_RWB    = 16'b0_0_0_1_0_1_0_00_00_00_0_0_0;
  localparam logic [15:0] C_BEQ    = 16'b0_0_0_0_0_0_1_00_01_01_0_1_0;
  localparam logic [15:0] C_AWB    = 16'b0_0_0_0_0_1_0_00_00_00_0_0_0;
  localparam logic [15:0] C_JEX    = 16'b0_0_0_0_0_0_0_00_00_10_1_0_0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [15:0] ctrl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [5:0] o, logic m, logic [3:0] s, logic [15:0] c);
    vec_t v;
    v.op = o; v.mr = m; v.st = s; v.ctrl = c;
    return v;
  endfunction

  function automatic logic [15:0] ctrl_now();
    return {iorD, memWrite, irWrite, regDst, memtoReg, regWrite, aluSrcA,
            aluSrcB, aluOp, pcSrc, pcWrite, branch, illegal_op};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  // Watchdog so the bench always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $finish;
  end

  initial begin
    // lw, no wait states: 0,1,2,3,4
    vecs.push_back(mk(LW, 1, 0, C_FETCH1));
    vecs.push_back(mk(LW, 1, 1, C_DEC));
    vecs.push_back(mk(LW, 1, 2, C_MEMADR));
    vecs.push_back(mk(LW, 1, 3, C_MEMRD));
    vecs.push_back(mk(LW, 1, 4, C_MEMWB));
    // lw, two wait cycles in MEMRD: 7 cycles
    vecs.push_back(mk(LW, 1, 0, C_FETCH1));
    vecs.push_back(mk(LW, 1, 1, C_DEC));
    vecs.push_back(mk(LW, 1, 2, C_MEMADR));
    vecs.push_back(mk(LW, 0, 3, C_MEMRD));
    vecs.push_back(mk(LW, 0, 3, C_MEMRD));
    vecs.push_back(mk(LW, 1, 3, C_MEMRD));
    vecs.push_back(mk(LW, 1, 4, C_MEMWB));
    // fetch stall, then R-type; mem_ready low in RTYPEEX is ignored
    vecs.push_back(mk(RT, 0, 0, C_FETCH0));
    vecs.push_back(mk(RT, 1, 0, C_FETCH1));
    vecs.push_back(mk(RT, 1, 1, C_DEC));
    vecs.push_back(mk(RT, 0, 6, C_REX));
    vecs.push_back(mk(RT, 1, 7, C_RWB));
    // beq
    vecs.push_back(mk(BEQ, 1, 0, C_FETCH1));
    vecs.push_back(mk(BEQ, 1, 1, C_DEC));
    vecs.push_back(mk(BEQ, 0, 8, C_BEQ));
    // addi
    vecs.push_back(mk(ADDI, 1, 0, C_FETCH1));
    vecs.push_back(mk(ADDI, 1, 1, C_DEC));
    vecs.push_back(mk(ADDI, 1, 9, C_MEMADR));
    vecs.push_back(mk(ADDI, 1, 10, C_AWB));
    // j
    vecs.push_back(mk(J, 1, 0, C_FETCH1));
    vecs.push_back(mk(J, 1, 1, C_DEC));
    vecs.push_back(mk(J, 1, 11, C_JEX));
    // sw with three wait cycles: memWrite for 4 cycles
    vecs.push_back(mk(SW, 1, 0, C_FETCH1));
    vecs.push_back(mk(SW, 1, 1, C_DEC));
    vecs.push_back(mk(SW, 1, 2, C_MEMADR));
    vecs.push_back(mk(SW, 0, 5, C_MEMWR));
    vecs.push_back(mk(SW, 0, 5, C_MEMWR));
    vecs.push_back(mk(SW, 0, 5, C_MEMWR));
    vecs.push_back(mk(SW, 1, 5, C_MEMWR));
    // illegal opcode: one-cycle pulse, straight back to FETCH
    vecs.push_back(mk(BAD, 1, 0, C_FETCH1));
    vecs.push_back(mk(BAD, 1, 1, C_DECILL));
    vecs.push_back(mk(LW, 1, 0, C_FETCH1));
    // lw up to MEMWB, where reset is hit asynchronously below
    vecs.push_back(mk(LW, 1, 1, C_DEC));
    vecs.push_back(mk(LW, 1, 2, C_MEMADR));
    vecs.push_back(mk(LW, 1, 3, C_MEMRD));
    vecs.push_back(mk(LW, 1, 4, C_MEMWB));

    // Reset held across clock edges
    reset_n   = 1'b0;
    op        = RT;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_ctrl", 32'(ctrl_now()), 32'(C_FETCH1));
    mem_ready = 1'b0;
    #1;
    check("reset_ctrl_mr0", 32'(ctrl_now()), 32'(C_FETCH0));

    // Release reset away from the clock edge
    @(negedge clk);
    reset_n   = 1'b1;
    mem_ready = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      op        = vecs[i].op;
      mem_ready = vecs[i].mr;
      #1;
      if ({state, ctrl_now()} !== {vecs[i].st, vecs[i].ctrl}) begin
        n_checks++;
        n_fail++;
        $display("FAIL vec%0d op=%b mr=%b: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 i, vecs[i].op, vecs[i].mr, state, ctrl_now(), vecs[i].st, vecs[i].ctrl);
      end else begin
        n_checks++;
      end
    end

    // Now in MEMWB, mid-cycle: reset must act without a clock edge
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset_state", 32'(state), 32'd0);
    check("async_reset_regWrite", 32'(regWrite), 32'd0);
    check("async_reset_memWrite", 32'(memWrite), 32'd0);

    // Release and confirm a fresh fetch proceeds to DECODE
    @(negedge clk);
    reset_n   = 1'b1;
    op        = J;
    mem_ready = 1'b1;
    #1;
    check("post_reset_state", 32'(state), 32'd0);
    @(negedge clk);
    #1;
    check("post_reset_decode", 32'(state), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_main_ctrl.md
Name: mips_main_ctrl

Overview:
- Multicycle MIPS main controller FSM. Sits directly upstream of the ALU decoder; the 2-bit aluOp it produces goes straight to that decoder.
- Decodes the instruction opcode over several cycles.
- Drives all datapath enables and muxes: PC, IR, register file, memory.
- Stalls on a memory ready handshake during instruction fetch and data access.

Parameters:
- MEM_HANDSHAKE, 1, when 1 memory states wait for mem_ready; when 0 mem_ready is treated as constant 1.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- op  input  6  opcode, instr[31:26], taken from the IR
- mem_ready  input  1  memory has completed the current read or write this cycle
- iorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- memWrite  output  1  memory write strobe
- irWrite  output  1  instruction register load enable
- regDst  output  1  write register select: 1 = rd, 0 = rt
- memtoReg  output  1  write-back select: 1 = data register, 0 = ALUOut
- regWrite  output  1  register file write enable
- aluSrcA  output  1  ALU A select: 0 = PC, 1 = register A
- aluSrcB  output  2  ALU B select: 00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2
- aluOp  output  2  to ALU decoder: 00 = add, 01 = sub, 10 = use funct
- pcSrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- pcWrite  output  1  unconditional PC write
- branch  output  1  conditional PC write; the datapath forms pcEn = pcWrite | (branch & zero)
- illegal_op  output  1  one-cycle pulse: an unsupported opcode was decoded
- state  output  4  current state, for debug

Behaviour:
- State register: 4 bits, cleared asynchronously to FETCH while reset_n = 0. Outputs are decoded from the current state.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Codes 12-15 are illegal; they go to FETCH on the next clock with all outputs 0.
- Default value of every output is 0; each state sets only the outputs listed below.
- Reset values: state = 0 and the FETCH outputs apply. aluSrcB = 01, aluOp = 00, irWrite = pcWrite = mem_ready, all other outputs 0.
- Let rdy = mem_ready when MEM_HANDSHAKE = 1, otherwise 1.
- FETCH: iorD = 0, aluSrcA = 0, aluSrcB = 01, aluOp = 00, pcSrc = 00.
  - irWrite = pcWrite = rdy.
  - Go to DECODE if rdy, else stay in FETCH. The PC and IR must not update while stalled.
- DECODE: aluSrcA = 0, aluSrcB = 11, aluOp = 00 (branch target into ALUOut). Next state by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 -> RTYPEEX
  - 000100 -> BEQEX
  - 001000 -> ADDIEX
  - 000010 -> JEX
  - any other opcode -> FETCH, with illegal_op = 1 for this cycle only. No register or memory write occurs.
- MEMADR: aluSrcA = 1, aluSrcB = 10, aluOp = 00. op = 100011 -> MEMRD, else MEMWR.
- MEMRD: iorD = 1. Go to MEMWB if rdy, else stay.
- MEMWB: regDst = 0, memtoReg = 1, regWrite = 1. Go to FETCH.
- MEMWR: iorD = 1, memWrite = 1, held for every cycle in this state. Go to FETCH if rdy, else stay.
- RTYPEEX: aluSrcA = 1, aluSrcB = 00, aluOp = 10. Go to RTYPEWB.
- RTYPEWB: regDst = 1, memtoReg = 0, regWrite = 1. Go to FETCH.
- BEQEX: aluSrcA = 1, aluSrcB = 00, aluOp = 01, pcSrc = 01, branch = 1. Go to FETCH.
- ADDIEX: aluSrcA = 1, aluSrcB = 10, aluOp = 00. Go to ADDIWB.
- ADDIWB: regDst = 0, memtoReg = 0, regWrite = 1. Go to FETCH.
- JEX: pcSrc = 10, pcWrite = 1. Go to FETCH.
- Latency with zero wait states (rdy = 1 every cycle), in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each memory wait cycle adds one cycle in FETCH, MEMRD or MEMWR.
- op is sampled only in DECODE and MEMADR; it is a don't-care in every other state.
- Reset asserted mid-instruction: the FSM returns to FETCH immediately, without waiting for a clock. Any partial regWrite or memWrite is abandoned, and no write strobe is active during reset.
- mem_ready high outside the memory states is ignored.

Test Plan:
- Reset: hold reset_n = 0, pulse clk -> state = 0, aluSrcB = 01, regWrite = memWrite = 0. Release reset with mem_ready = 1 -> next state = 1.
- lw, op = 100011, mem_ready = 1 -> states 0,1,2,3,4,0. MEMWB has regWrite = 1, memtoReg = 1. Repeat with mem_ready low for 2 cycles in MEMRD -> state 3 held 3 cycles, 7 cycles total.
- R-type, op = 000000 -> RTYPEEX has aluOp = 10, aluSrcA = 1, aluSrcB = 00; RTYPEWB has regDst = 1, regWrite = 1; 4 cycles.
- beq, op = 000100 -> BEQEX has aluOp = 01, branch = 1, pcSrc = 01, pcWrite = 0. j, op = 000010 -> JEX has pcSrc = 10, pcWrite = 1.
- sw, op = 101011, mem_ready low 3 cycles in MEMWR -> memWrite = 1 for 4 consecutive cycles, then FETCH. Illegal op = 111111 -> illegal_op = 1 for exactly 1 cycle, then FETCH, no write strobes.
- Deassert reset_n mid-cycle in MEMWB -> state = 0 and regWrite = 0 asynchronously, before the next clk edge.
